id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage_if.sv | 19 +
 rtl/id_stage.sv | 85 ++++++++
 tb/tb_id_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// id_stage_if: IF fetch, WB write, MEM hazard inputs and ID/EX outputs of the decode stage.
interface id_stage_if #(parameter int XLEN = 19);
  logic [XLEN-1:0] pc, instruction, branch_target, wb_data;
  logic [XLEN-1:0] ex_rs1_val, ex_rs2_val, ex_imm, ex_pc;
  logic branch_taken, stall, wb_en, mem_reg_write;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, illegal;
  logic [2:0] wb_addr, mem_rd, ex_rd;
  logic [3:0] ex_op;
  modport master (
    output pc, instruction, wb_en, wb_addr, wb_data, mem_rd, mem_reg_write,
    input branch_taken, branch_target, stall, ex_valid, ex_op, ex_rd, ex_rs1_val,
          ex_rs2_val, ex_imm, ex_pc, ex_reg_write, ex_mem_read, ex_mem_write, illegal
  );
  modport slave (
    input pc, instruction, wb_en, wb_addr, wb_data, mem_rd, mem_reg_write,
    output branch_taken, branch_target, stall, ex_valid, ex_op, ex_rd, ex_rs1_val,
           ex_rs2_val, ex_imm, ex_pc, ex_reg_write, ex_mem_read, ex_mem_write, illegal
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: decode with register file, load-use/branch stalls and branch resolution in ID.
module id_stage #(parameter int XLEN = 19) (
  input logic clk,
  input logic rst_n,
  id_stage_if.slave bus
);
  logic [XLEN-1:0] id_pc, id_instr, v1, v2, imm, off;
  logic [XLEN-1:0] rf [8];
  logic id_valid, bad, is_br, is_jmp, reg_write, use1, use2, load_use, br_stall, issue;
  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;

  function automatic logic hit(input logic [2:0] r, input logic [2:0] er, input logic ew,
                               input logic [2:0] mr, input logic mw);
    return r != 3'd0 && ((ew && r == er) || (mw && r == mr));
  endfunction

  always_comb begin
    op = id_instr[18:15];
    rd = id_instr[14:12];
    rs1 = id_instr[11:9];
    is_br = op == 4'd9 || op == 4'd10;
    is_jmp = op == 4'd11;
    bad = op >= 4'd12;
    rs2 = (is_br || op == 4'd8) ? rd : id_instr[8:6];
    use1 = op != 4'd0 && op <= 4'd10;
    use2 = (op != 4'd0 && op <= 4'd5) || (op >= 4'd8 && op <= 4'd10);
    reg_write = op != 4'd0 && op <= 4'd7;
    v1 = rs1 == 3'd0 ? '0 : (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : rf[rs1];
    v2 = rs2 == 3'd0 ? '0 : (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : rf[rs2];
    imm = {{(XLEN-9){id_instr[8]}}, id_instr[8:0]};
    off = is_jmp ? {{(XLEN-15){id_instr[14]}}, id_instr[14:0]} : imm;
    load_use = bus.ex_valid && bus.ex_mem_read && bus.ex_rd != 3'd0 &&
               ((use1 && rs1 == bus.ex_rd) || (use2 && rs2 == bus.ex_rd));
    br_stall = is_br && (hit(rs1, bus.ex_rd, bus.ex_valid && bus.ex_reg_write, bus.mem_rd, bus.mem_reg_write) ||
                         hit(rs2, bus.ex_rd, bus.ex_valid && bus.ex_reg_write, bus.mem_rd, bus.mem_reg_write));
    bus.stall = id_valid && (load_use || br_stall);
    issue = id_valid && !bus.stall;
    bus.branch_taken = issue && (is_jmp || (op == 4'd9 && v1 == v2) || (op == 4'd10 && v1 != v2));
    bus.branch_target = bus.branch_taken ? id_pc + off : '0;
  end

  // IF/ID holds on stall; a taken branch squashes the wrong-path fetch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      id_pc <= '0;
      id_instr <= '0;
      id_valid <= 1'b0;
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else begin
      if (bus.wb_en && bus.wb_addr != 3'd0) rf[bus.wb_addr] <= bus.wb_data;
      if (!bus.stall) begin
        id_pc <= bus.pc;
        id_instr <= bus.instruction;
        id_valid <= !bus.branch_taken;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.ex_valid <= 1'b0;
      bus.ex_op <= '0;
      bus.ex_rd <= '0;
      bus.ex_rs1_val <= '0;
      bus.ex_rs2_val <= '0;
      bus.ex_imm <= '0;
      bus.ex_pc <= '0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read <= 1'b0;
      bus.ex_mem_write <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      bus.ex_valid <= issue;
      bus.ex_op <= issue && !bad ? op : '0;
      bus.ex_rd <= issue && reg_write ? rd : '0;
      bus.ex_rs1_val <= issue ? v1 : '0;
      bus.ex_rs2_val <= issue ? v2 : '0;
      bus.ex_imm <= issue ? off : '0;
      bus.ex_pc <= issue ? id_pc : '0;
      bus.ex_reg_write <= issue && reg_write;
      bus.ex_mem_read <= issue && op == 4'd7;
      bus.ex_mem_write <= issue && op == 4'd8;
      bus.illegal <= issue && bad;
    end
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed vector table plus randomized run against a behavioural decode model.
module tb_id_stage;
  localparam int XLEN = 19;
  typedef logic [XLEN-1:0] w_t;
  typedef struct packed {
    logic v; logic [3:0] op; logic [2:0] rd; w_t a, b, imm, pc; logic rw, mr, mw, il;
  } ex_t;
  typedef struct {
    w_t pc, ins; logic st, tk; w_t tg; logic ev; w_t r1, r2, im; logic il, rw;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  id_stage_if #(.XLEN(XLEN)) bus();
  id_stage #(.XLEN(XLEN)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));

  int passed = 0, total = 0;
  w_t m_pc, m_ins;
  w_t m_rf [8];
  logic m_v;
  ex_t m_ex;
  vec_t vt [15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic ex_t dut_ex();
    return {bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm,
            bus.ex_pc, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.illegal};
  endfunction

  function automatic w_t enc(input int op, input int rd, input int rs1, input int lo);
    return {4'(op), 3'(rd), 3'(rs1), 9'(lo)};
  endfunction

  function automatic vec_t mk(input int pc, input w_t ins, input int st, input int tk, input int tg,
                              input int ev, input int r1, input int r2, input int im, input int il, input int rw);
    return '{w_t'(pc), ins, 1'(st), 1'(tk), w_t'(tg), 1'(ev), w_t'(r1), w_t'(r2), w_t'(im), 1'(il), 1'(rw)};
  endfunction

  function automatic w_t rd_val(input logic [2:0] r);
    if (r == 3'd0) return '0;
    if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
    return m_rf[r];
  endfunction

  // a register produced by EX (writing) or MEM blocks a branch that compares it
  function automatic logic pending(input logic [2:0] r);
    return r != 3'd0 && ((m_ex.v && m_ex.rw && r == m_ex.rd) || (bus.mem_reg_write && r == bus.mem_rd));
  endfunction

  task automatic model_reset();
    m_pc = '0; m_ins = '0; m_v = 1'b0; m_ex = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
  endtask

  task automatic drive(input w_t pc, input w_t ins, input logic we, input logic [2:0] wa, input w_t wd,
                       input logic [2:0] mrd, input logic mrw);
    bus.pc = pc; bus.instruction = ins; bus.wb_en = we; bus.wb_addr = wa; bus.wb_data = wd;
    bus.mem_rd = mrd; bus.mem_reg_write = mrw;
  endtask

  // one cycle: check ID combinational outputs, take the edge, check the ID/EX register
  task automatic step(input string tag, output logic s, output logic t, output w_t g);
    logic [3:0] op;
    logic [2:0] a, b;
    logic ua, ub, st, tk, wr, we;
    logic [2:0] wa;
    w_t va, vb, tg, wd, pc_in, ins_in;
    int o;
    ex_t nx;
    #1;
    op = m_ins[18:15];
    a = m_ins[11:9];
    b = (op == 8 || op == 9 || op == 10) ? m_ins[14:12] : m_ins[8:6];
    ua = op >= 1 && op <= 10;
    ub = (op >= 1 && op <= 5) || (op >= 8 && op <= 10);
    va = rd_val(a);
    vb = rd_val(b);
    o = op == 11 ? int'($signed(m_ins[14:0])) : int'($signed(m_ins[8:0]));
    st = m_v && ((m_ex.v && m_ex.mr && m_ex.rd != 0 && ((ua && a == m_ex.rd) || (ub && b == m_ex.rd))) ||
                 ((op == 9 || op == 10) && (pending(a) || pending(b))));
    tk = m_v && !st && (op == 11 || (op == 9 && va == vb) || (op == 10 && va != vb));
    tg = tk ? w_t'(int'(m_pc) + o) : '0;
    s = bus.stall; t = bus.branch_taken; g = bus.branch_target;
    chk({tag, " stall"}, s, st);
    chk({tag, " taken"}, t, tk);
    chk({tag, " target"}, g, tg);
    wr = op >= 1 && op <= 7;
    nx = (m_v && !st) ? '{v: 1'b1, op: op >= 12 ? 4'd0 : op, rd: wr ? m_ins[14:12] : 3'd0, a: va, b: vb,
                          imm: w_t'(o), pc: m_pc, rw: wr, mr: op == 7, mw: op == 8, il: op >= 12} : '0;
    we = bus.wb_en; wa = bus.wb_addr; wd = bus.wb_data; pc_in = bus.pc; ins_in = bus.instruction;
    @(posedge clk);
    #1;
    if (we && wa != 0) m_rf[wa] = wd;
    m_ex = nx;
    if (!st) begin
      m_pc = pc_in; m_ins = ins_in; m_v = !tk;
    end
    chk({tag, " ex"}, dut_ex(), m_ex);
  endtask

  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    chk({tag, " outs"}, {bus.stall, bus.branch_taken, bus.branch_target, bus.illegal}, '0);
    chk({tag, " ex"}, dut_ex(), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic s, t;
    w_t g;
    drive('0, '0, 1'b0, '0, '0, '0, 1'b0);
    vt[0]  = mk(0, enc(6, 1, 0, 5), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(1, enc(1, 2, 1, 64), 0, 0, 0, 1, 0, 0, 5, 0, 1);
    vt[2]  = mk(2, enc(7, 3, 0, 0), 0, 0, 0, 1, 5, 5, 64, 0, 1);
    vt[3]  = mk(3, enc(1, 4, 3, 0), 0, 0, 0, 1, 0, 0, 0, 0, 1);
    vt[4]  = mk(4, enc(0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[5]  = mk(4, enc(0, 0, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0, 1);
    vt[6]  = mk(10, enc(9, 0, 0, 128), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vt[7]  = mk(11, enc(6, 5, 0, 7), 0, 1, 138, 1, 0, 0, 128, 0, 0);
    vt[8]  = mk(138, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[9]  = mk(139, enc(10, 0, 0, 5), 0, 0, 0, 1, 0, 0, 0, 0, 0);
    vt[10] = mk('h7FFFF, enc(11, 0, 0, 1), 0, 0, 0, 1, 0, 0, 5, 0, 0);
    vt[11] = mk(0, '0, 0, 1, 0, 1, 0, 0, 1, 0, 0);
    vt[12] = mk(0, enc(13, 1, 0, 0), 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vt[13] = mk(1, '0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
    vt[14] = mk(2, '0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset outs", {bus.stall, bus.branch_taken, bus.branch_target, bus.illegal}, '0);
    chk("reset ex", dut_ex(), '0);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].pc, vt[i].ins, i == 2, i == 2 ? 3'd1 : 3'd0, i == 2 ? w_t'(5) : '0, '0, 1'b0);
      step($sformatf("vec%0d", i), s, t, g);
      chk($sformatf("vec%0d comb", i), {s, t, g}, {vt[i].st, vt[i].tk, vt[i].tg});
      chk($sformatf("vec%0d idex", i),
          {bus.ex_valid, bus.ex_rs1_val, bus.ex_rs2_val, bus.ex_imm, bus.illegal, bus.ex_reg_write},
          {vt[i].ev, vt[i].r1, vt[i].r2, vt[i].im, vt[i].il, vt[i].rw});
    end
    drive(w_t'(20), enc(7, 3, 0, 0), 1'b0, '0, '0, '0, 1'b0);
    step("ms ld", s, t, g);
    drive(w_t'(21), enc(1, 4, 3, 0), 1'b0, '0, '0, '0, 1'b0);
    step("ms add", s, t, g);
    drive(w_t'(22), '0, 1'b0, '0, '0, '0, 1'b0);
    #1 chk("ms stall", bus.stall, 1'b1);
    mid_reset("ms rst");
    for (int i = 0; i < 600; i++) begin
      drive(w_t'($urandom), {4'($urandom_range(0, 15)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            9'($urandom)}, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 4)), w_t'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 80) == 0) mid_reset("rnd rst");
      else step("rnd", s, t, g);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
